// File: rtl/led_mode_ctrl_pkg.sv
// Shared definitions for the LED mode controller: mode encodings,
// per-mode step lengths and the (mode, step) -> LED pattern lookup.
package led_mode_ctrl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_BLINK = 2'd0;
  localparam mode_t MODE_CHASE = 2'd1;
  localparam mode_t MODE_COUNT = 2'd2;
  localparam mode_t MODE_ALT   = 2'd3;

  // Index of the last step in each mode; the step counter wraps after it.
  localparam logic [2:0] LAST_STEP_BLINK = 3'd1;
  localparam logic [2:0] LAST_STEP_CHASE = 3'd2;
  localparam logic [2:0] LAST_STEP_COUNT = 3'd7;
  localparam logic [2:0] LAST_STEP_ALT   = 3'd1;

  function automatic logic [2:0] last_step(input mode_t mode);
    logic [2:0] last;
    case (mode)
      MODE_BLINK: last = LAST_STEP_BLINK;
      MODE_CHASE: last = LAST_STEP_CHASE;
      MODE_COUNT: last = LAST_STEP_COUNT;
      default:    last = LAST_STEP_ALT;
    endcase
    return last;
  endfunction

  // LED drive for a given mode and step; bit 0 is led_1.
  function automatic logic [2:0] led_pattern(input mode_t mode, input logic [2:0] step);
    logic [2:0] pat;
    pat = 3'b000;
    case (mode)
      MODE_BLINK: pat = (step == 3'd0) ? 3'b111 : 3'b000;
      MODE_CHASE: begin
        case (step)
          3'd0:    pat = 3'b001;
          3'd1:    pat = 3'b010;
          3'd2:    pat = 3'b100;
          default: pat = 3'b000;
        endcase
      end
      MODE_COUNT: pat = step;
      default:    pat = (step == 3'd0) ? 3'b101 : 3'b010;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// Board-facing pins of the LED mode controller: two raw keys in,
// LED drive plus mode/pause status out.
interface led_mode_ctrl_if;
  import led_mode_ctrl_pkg::*;

  logic       key_mode_n;
  logic       key_pause_n;
  logic [2:0] led;
  mode_t      mode_o;
  logic       paused_o;

  modport master (
    output key_mode_n,
    output key_pause_n,
    input  led,
    input  mode_o,
    input  paused_o
  );

  modport slave (
    input  key_mode_n,
    input  key_pause_n,
    output led,
    output mode_o,
    output paused_o
  );

endinterface

// File: rtl/led_mode_ctrl_key_debounce.sv
// Key front-end: 2-FF synchroniser, stability counter, and a one-cycle
// press pulse on each accepted released->pressed transition.
module led_mode_ctrl_key_debounce #(
  parameter logic [19:0] DEB_CNT = 20'd1000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic press
);

  logic        sync_ff1;
  logic        sync_ff2;
  logic        key_level;
  logic [19:0] deb_cnt;

  // Synchronise the raw key, accept a new level only after it has been stable long enough.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_ff1  <= 1'b1;
      sync_ff2  <= 1'b1;
      key_level <= 1'b1;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      sync_ff1 <= key_n;
      sync_ff2 <= sync_ff1;
      press    <= 1'b0;
      if (sync_ff2 == key_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_CNT - 20'd1) begin
        deb_cnt   <= '0;
        key_level <= sync_ff2;
        press     <= ~sync_ff2;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end
  end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller top: step timebase, mode and pause state machines,
// and the registered LED pattern output.
module led_mode_ctrl
  import led_mode_ctrl_pkg::*;
#(
  parameter logic [31:0] TICK_CNT = 32'd12500000,
  parameter logic [19:0] DEB_CNT  = 20'd1000000
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  led_mode_ctrl_if.slave pins
);

  localparam logic [0:0] PS_RUN  = 1'b0;
  localparam logic [0:0] PS_HOLD = 1'b1;

  logic        mode_press;
  logic        pause_press;
  mode_t       mode_q;
  logic [0:0]  pause_q;
  logic [2:0]  step_q;
  logic [31:0] tick_cnt_q;
  logic [2:0]  led_q;
  logic        tick;

  led_mode_ctrl_key_debounce #(.DEB_CNT(DEB_CNT)) u_key_mode (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (pins.key_mode_n),
    .press     (mode_press)
  );

  led_mode_ctrl_key_debounce #(.DEB_CNT(DEB_CNT)) u_key_pause (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n     (pins.key_pause_n),
    .press     (pause_press)
  );

  // A step tick only fires while running; a held counter must not retrigger.
  assign tick = (pause_q == PS_RUN) && (tick_cnt_q == TICK_CNT - 32'd1);

  // Mode FSM: each mode press advances BLINK -> CHASE -> COUNT -> ALT -> BLINK.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q <= MODE_BLINK;
    end else if (mode_press) begin
      case (mode_q)
        MODE_BLINK: mode_q <= MODE_CHASE;
        MODE_CHASE: mode_q <= MODE_COUNT;
        MODE_COUNT: mode_q <= MODE_ALT;
        default:    mode_q <= MODE_BLINK;
      endcase
    end
  end

  // Pause FSM: each pause press toggles between RUN and HOLD.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pause_q <= PS_RUN;
    end else if (pause_press) begin
      pause_q <= (pause_q == PS_RUN) ? PS_HOLD : PS_RUN;
    end
  end

  // Timebase and step: a mode press restarts both and wins over a coincident tick.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt_q <= '0;
      step_q     <= '0;
    end else if (mode_press) begin
      tick_cnt_q <= '0;
      step_q     <= '0;
    end else if (pause_q == PS_RUN) begin
      if (tick) begin
        tick_cnt_q <= '0;
        step_q     <= (step_q == last_step(mode_q)) ? 3'd0 : step_q + 3'd1;
      end else begin
        tick_cnt_q <= tick_cnt_q + 32'd1;
      end
    end
  end

  // Registered LED drive, one cycle behind the mode/step registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q <= 3'b000;
    end else begin
      led_q <= led_pattern(mode_q, step_q);
    end
  end

  assign pins.led      = led_q;
  assign pins.mode_o   = mode_q;
  assign pins.paused_o = (pause_q == PS_HOLD);

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with TICK_CNT=4, DEB_CNT=8.
// Timeline is expressed in absolute cycle numbers; every check samples
// 1 time unit after the rising edge.
module tb_led_mode_ctrl;

  logic sys_clk;
  logic sys_rst_n;
  int   cyc;
  int   assert_cnt;
  int   fail_cnt;

  led_mode_ctrl_if bus_if ();

  led_mode_ctrl #(
    .TICK_CNT (32'd4),
    .DEB_CNT  (20'd8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pins      (bus_if.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Count rising edges so stimulus and checks can be placed on absolute cycles.
  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic atCycle(input int n);
    while (cyc < n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkLed(input string tag, input logic [2:0] exp);
    checkOutput(tag, 32'(bus_if.led), 32'(exp));
  endtask

  task automatic checkState(input string tag, input logic [2:0] led_exp,
                            input logic [1:0] mode_exp, input logic paused_exp);
    checkOutput({tag, ".led"}, 32'(bus_if.led), 32'(led_exp));
    checkOutput({tag, ".mode"}, 32'(bus_if.mode_o), 32'(mode_exp));
    checkOutput({tag, ".paused"}, 32'(bus_if.paused_o), 32'(paused_exp));
  endtask

  task automatic applyStimulus(input bit is_pause, input logic level);
    if (is_pause) bus_if.key_pause_n = level;
    else          bus_if.key_mode_n  = level;
  endtask

  // Hard stop in case the timeline ever stalls.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    assert_cnt = 0;
    fail_cnt   = 0;
    sys_rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);

    // Reset and release: BLINK phase starts at cycle 3
    atCycle(3);
    checkState("in_reset", 3'b000, 2'd0, 1'b0);
    sys_rst_n = 1'b1;
    #1;
    checkState("after_release", 3'b000, 2'd0, 1'b0);
    atCycle(4);  checkState("blink_on", 3'b111, 2'd0, 1'b0);
    atCycle(7);  checkLed("blink_on_end", 3'b111);
    atCycle(8);  checkLed("blink_off", 3'b000);
    atCycle(11); checkLed("blink_off_end", 3'b000);
    atCycle(12); checkLed("blink_on_again", 3'b111);

    // Short glitch on the mode key is rejected
    atCycle(14); applyStimulus(1'b0, 1'b0);
    atCycle(19); applyStimulus(1'b0, 1'b1);
    atCycle(35); checkState("short_press", 3'b000, 2'd0, 1'b0);

    // Long press: mode event lands at cycle 51, CHASE phase from there
    atCycle(40); applyStimulus(1'b0, 1'b0);
    atCycle(50); checkOutput("mode_before_evt", 32'(bus_if.mode_o), 32'd0);
    atCycle(51); checkOutput("mode_after_evt", 32'(bus_if.mode_o), 32'd1);
    atCycle(52); checkLed("chase_0", 3'b001);
    atCycle(56); checkLed("chase_1", 3'b010);
    atCycle(60); checkLed("chase_2", 3'b100);
    applyStimulus(1'b0, 1'b1);
    atCycle(64); checkState("chase_wrap", 3'b001, 2'd1, 1'b0);

    // COUNT mode: event at cycle 91
    atCycle(80); applyStimulus(1'b0, 1'b0);
    atCycle(92); applyStimulus(1'b0, 1'b1);
    checkState("count_0", 3'b000, 2'd2, 1'b0);
    atCycle(96);  checkLed("count_1", 3'b001);
    atCycle(120); checkLed("count_7", 3'b111);
    atCycle(124); checkLed("count_wrap", 3'b000);

    // Pause at step 3 of the second COUNT pass: event at cycle 136
    atCycle(125); applyStimulus(1'b1, 1'b0);
    atCycle(135); checkState("pre_pause", 3'b010, 2'd2, 1'b0);
    atCycle(136); checkState("paused", 3'b011, 2'd2, 1'b1);
    atCycle(137); applyStimulus(1'b1, 1'b1);
    atCycle(236); checkState("held_100cyc", 3'b011, 2'd2, 1'b1);

    // Resume: event at cycle 251, held count of 1 means next step lands at 254
    atCycle(240); applyStimulus(1'b1, 1'b0);
    atCycle(251); checkState("resumed", 3'b011, 2'd2, 1'b0);
    atCycle(252); applyStimulus(1'b1, 1'b1);
    atCycle(254); checkLed("resume_hold", 3'b011);
    atCycle(255); checkLed("resume_step", 3'b100);

    // ALT mode: event at cycle 271
    atCycle(260); applyStimulus(1'b0, 1'b0);
    atCycle(272); checkState("alt_0", 3'b101, 2'd3, 1'b0);
    applyStimulus(1'b0, 1'b1);
    atCycle(276); checkLed("alt_1", 3'b010);

    // Mode press coincident with a tick at cycle 295
    atCycle(284); applyStimulus(1'b0, 1'b0);
    atCycle(294); checkState("pre_coincide", 3'b010, 2'd3, 1'b0);
    atCycle(296); checkState("coincide", 3'b111, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    atCycle(299); checkLed("coincide_hold", 3'b111);
    atCycle(300); checkLed("coincide_next", 3'b000);

    // Pause in BLINK (event 311), then mode press while paused (event 331)
    applyStimulus(1'b1, 1'b0);
    atCycle(312); applyStimulus(1'b1, 1'b1);
    checkState("blink_paused", 3'b111, 2'd0, 1'b1);
    atCycle(318); checkLed("blink_frozen", 3'b111);
    atCycle(320); applyStimulus(1'b0, 1'b0);
    atCycle(332); checkState("mode_while_paused", 3'b001, 2'd1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    atCycle(360); checkState("still_paused", 3'b001, 2'd1, 1'b1);

    // Unpause (event 376) and go to COUNT (event 391)
    atCycle(365); applyStimulus(1'b1, 1'b0);
    atCycle(376); checkOutput("unpaused", 32'(bus_if.paused_o), 32'd0);
    atCycle(377); applyStimulus(1'b1, 1'b1);
    atCycle(380); applyStimulus(1'b0, 1'b0);
    atCycle(392); applyStimulus(1'b0, 1'b1);

    // Asynchronous reset in the middle of COUNT step 5
    atCycle(413); checkState("count_5", 3'b101, 2'd2, 1'b0);
    #4;
    sys_rst_n = 1'b0;
    #1;
    checkState("async_reset", 3'b000, 2'd0, 1'b0);
    atCycle(416); checkState("reset_held", 3'b000, 2'd0, 1'b0);
    sys_rst_n = 1'b1;
    atCycle(417); checkState("rerelease_on", 3'b111, 2'd0, 1'b0);
    atCycle(420); checkLed("rerelease_on_end", 3'b111);
    atCycle(421); checkState("rerelease_off", 3'b000, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Controller that sequences the board's three user LEDs through selectable display modes under control of two push keys. The block owns the step timebase, a debounced key front-end, and a mode/pause state machine. It replaces the fixed free-running blink with a user-selectable sequence. It sits directly between the board key pins, the board LED pins, and the sys_clk / sys_rst_n domain.

Parameters:
TICK_CNT, 32'd12500000, sys_clk cycles per pattern step (250 ms at 50 MHz); legal range >= 2.
DEB_CNT, 20'd1000000, consecutive stable cycles required to accept a key level (20 ms at 50 MHz); legal range >= 2.

Ports:
sys_clk  input  1  system clock, 50 MHz.
sys_rst_n  input  1  asynchronous active-low reset.
key_mode_n  input  1  raw mode key, active-low, asynchronous to sys_clk.
key_pause_n  input  1  raw pause key, active-low, asynchronous to sys_clk.
led  output  3  LED drive, 1 = on; led[0] = led_1.
mode_o  output  2  current mode (0 BLINK, 1 CHASE, 2 COUNT, 3 ALT).
paused_o  output  1  1 while stepping is frozen.

Behaviour:
- Reset: sys_rst_n, asynchronous, active-low; clock sys_clk. All flops clear asynchronously. led = 3'b000, mode_o = 0, paused_o = 0, step = 0, tick counter = 0, both debounced levels = released (1).
- Key front-end (per key): 2-FF synchroniser, then a DEB_CNT counter. The counter clears whenever the synchronised level equals the debounced level. When it reaches DEB_CNT-1 with the levels still different, the debounced level takes the new value. A press event is a 1-cycle pulse on a debounced 1->0 transition; release produces no event. Pulses shorter than DEB_CNT cycles produce no event.
- Tick counter: counts 0..TICK_CNT-1 and wraps to 0. tick pulses in the cycle the count equals TICK_CNT-1. The counter holds while paused.
- Step wrap length per mode: BLINK 2, CHASE 3, COUNT 8, ALT 2. On tick, step increments; on the last step it wraps to 0. Step is 3 bits wide.
- Patterns from (mode, step):
  - BLINK: 111, 000.
  - CHASE: 001, 010, 100.
  - COUNT: led = step (000..111).
  - ALT: 101, 010.
- led is registered: led <= pattern(mode, step). It lags a mode/step register change by exactly 1 cycle.
- Mode FSM: 4 states, advancing BLINK->CHASE->COUNT->ALT->BLINK on each mode press event.
- On a mode press: step <= 0 and tick counter <= 0 in the same cycle.
- Pause FSM: 2 states, RUN and HOLD. Each pause press event toggles between them. paused_o = (state == HOLD).
- Simultaneous events:
  - Mode press and tick in the same cycle: mode press wins. Step becomes 0, not incremented.
  - Mode press and pause press in the same cycle: both are applied.
  - Mode press while paused: mode advances and step = 0, so led shows the new mode's step-0 pattern. The block stays paused.
- Reset mid-operation: outputs go to their reset values immediately, without waiting for a clock edge. Any in-progress debounce count is discarded.

Decomposition:
- Shared package/header holds the mode encodings MODE_BLINK..MODE_ALT, per-mode step lengths, and the pattern lookup function.
- Natural sub-module: key_debounce (synchroniser + counter + press-pulse output). Instantiate it twice.

Test Plan:
All scenarios use TICK_CNT=4 and DEB_CNT=8.
1. Reset release with keys idle -> led 000 in the first cycle after release, then 111. led toggles 111/000 every 4 cycles. mode_o=0 and paused_o=0 throughout.
2. Debounce: key_mode_n low for 5 cycles then high -> mode_o stays 0. key_mode_n low for 20 cycles -> mode_o=1 exactly once, within 11 cycles of the falling edge. Then led=001.
3. CHASE sequence: led reads 001, 010, 100, 001 at 4-cycle intervals. COUNT mode: led 000..111 then wraps to 000 after 32 cycles.
4. Pause: press key_pause_n during COUNT at step 3 -> led holds 011 for 100 cycles. Second press -> stepping resumes from the held tick count; next change is to 100.
5. Mode press coincident with a tick in ALT -> mode_o=0 and led=111 (BLINK step 0), not 000. Mode press while paused -> new mode's step-0 pattern is shown and paused_o stays 1.
6. Assert sys_rst_n low mid-cycle while in COUNT step 5 -> led=000, mode_o=0, paused_o=0 immediately. On release, behaviour matches scenario 1.
